eth_stream_arbiter: RTL

- Shares the single Ethernet-bound stream output between the per-channel AXI tap submodules (AW, W, B, AR, R).
- Each tap presents valid/in_progress/data and waits for ready. This block grants one tap at a time in round-robin order and holds the grant for the whole multi-beat packet (e.g. R data beat then resp beat).
- Output is one registered stage tagged with the source index. A watchdog releases a stalled grant.

---
 rtl/eth_helper_pkg.sv | 32 +++
 rtl/rr_priority_pick.sv | 27 ++
 rtl/eth_stream_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/eth_helper_pkg.sv
// Shared types and constants for the Ethernet stream arbiter: FSM state,
// AXI tap source indices and a reference round-robin pick for the 5-tap case.
package eth_helper_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  localparam int unsigned NUM_SRC = 5;
  localparam logic [2:0] SRC_AW = 3'd0;
  localparam logic [2:0] SRC_W  = 3'd1;
  localparam logic [2:0] SRC_B  = 3'd2;
  localparam logic [2:0] SRC_AR = 3'd3;
  localparam logic [2:0] SRC_R  = 3'd4;

  // First set bit of req searching ptr+1, ptr+2, ... wrapping at NUM_SRC.
  function automatic logic [2:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                         input logic [2:0]         ptr);
    logic [2:0] idx;
    logic       found;
    int         j;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      j = (int'(ptr) + k) % int'(NUM_SRC);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = 3'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set request after ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ   = 5,
  parameter int unsigned SRC_WIDTH = 3
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic [SRC_WIDTH-1:0] idx,
  output logic                 found
);

  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      j = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SRC_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin packet arbiter merging the AXI tap streams onto one registered
// output beat, locking a grant for a whole packet with a stall watchdog.
module eth_stream_arbiter
  import eth_helper_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 5,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned SRC_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_in_progress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [SRC_WIDTH-1:0]          m_src,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clear
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]  grant_q, grant_d;
  logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SRC_WIDTH-1:0]  m_src_q, m_src_d;
  logic                  m_last_q, m_last_d;
  logic                  err_q, err_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  logic [SRC_WIDTH-1:0]  pick_idx;
  logic                  pick_found;
  logic                  g_valid, g_ip, out_room, stall, xfer;
  int                    sel_lo;

  rr_priority_pick #(
    .NUM_REQ   (NUM_REQ),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    m_last_d  = m_last_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    req_ready = '0;

    sel_lo   = int'(grant_q) * int'(DATA_WIDTH);
    g_valid  = req_valid[grant_q];
    g_ip     = req_in_progress[grant_q];
    out_room = !m_valid_q || m_ready;
    stall    = m_valid_q && !m_ready;
    xfer     = (state_q == LOCK) && g_valid && out_room;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (err_clear) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = out_room;
        if (xfer) begin
          m_valid_d = 1'b1;
          m_data_d  = req_data[sel_lo +: DATA_WIDTH];
          m_src_d   = grant_q;
          m_last_d  = !g_ip;
          wdog_d    = '0;
          if (!g_ip) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end
        end else if (!g_valid && !g_ip) begin
          // Tap withdrew before finishing: release without inventing a last beat.
          state_d  = IDLE;
          rr_ptr_d = grant_q;
          wdog_d   = '0;
        end else if (TIMEOUT_CYCLES != 0 && wdog_q == WD_W'(TIMEOUT_CYCLES)) begin
          err_d    = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = grant_q;
          wdog_d   = '0;
        end else if (TIMEOUT_CYCLES != 0 && !stall) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= SRC_WIDTH'(NUM_REQ - 1);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_src       = m_src_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q == LOCK);
  assign err_timeout = err_q;

endmodule
